// File: rtl/dtc_arb_pkg.sv
// Shared types and helpers for the InputDTC frame-bus arbiter.
package dtc_arb_pkg;

  typedef enum logic {
    IDLE,
    BUSY
  } arb_state_t;

  localparam int DTC_N_LINKS = 4;
  localparam int DTC_DATA_W  = 64;

  // First set bit of cand scanning upward from ptr+1, wrapping at n; returns ptr if none.
  function automatic int unsigned rr_next(input logic [15:0] cand,
                                          input int unsigned ptr,
                                          input int unsigned n);
    rr_next = ptr;
    for (int unsigned k = n; k >= 1; k--) begin
      if (cand[4'((ptr + k) % n)]) rr_next = (ptr + k) % n;
    end
  endfunction

endpackage

// File: rtl/sticky_flag.sv
// Single-bit flag that sets on demand and clears only on reset.
module sticky_flag (
  input  logic clk,
  input  logic reset,
  input  logic set,
  output logic q
);

  always_ff @(posedge clk) begin
    if (reset)    q <= 1'b0;
    else if (set) q <= 1'b1;
  end

endmodule

// File: rtl/dtc_input_arbiter.sv
// Round-robin arbiter sharing one frame bus between N_LINKS DTC input links.
// Optional stalled-frame watchdog is built when DTC_ARB_TIMEOUT_EN is defined.
module dtc_input_arbiter
  import dtc_arb_pkg::*;
#(
  parameter int N_LINKS = DTC_N_LINKS,
  parameter int DATA_W  = DTC_DATA_W,
  parameter int LINK_W  = $clog2(N_LINKS),
  parameter int TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [N_LINKS-1:0]        req_valid,
  input  logic [N_LINKS-1:0]        req_last,
  input  logic [N_LINKS*DATA_W-1:0] req_data,
  output logic [N_LINKS-1:0]        req_ready,
  output logic                      out_valid,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_last,
  output logic [LINK_W-1:0]         out_src,
  input  logic                      out_ready,
  output logic [N_LINKS-1:0]        armed,
  output logic                      timeout_err
);

  arb_state_t         state, state_nxt;
  logic [LINK_W-1:0]  ptr, ptr_nxt;
  logic [LINK_W-1:0]  grant, grant_nxt;
  logic [N_LINKS-1:0] cand;
  logic [DATA_W-1:0]  lane [N_LINKS];
  logic               busy;
  logic               xfer;
  logic               abort;

  for (genvar i = 0; i < N_LINKS; i++) begin : g_link
    sticky_flag u_arm (
      .clk   (clk),
      .reset (reset),
      .set   (req_valid[i] & enable),
      .q     (armed[i])
    );
    assign lane[i] = req_data[i*DATA_W +: DATA_W];
  end

  assign cand    = armed & req_valid;
  assign busy    = (state == BUSY);
  assign xfer    = busy & req_valid[grant] & out_ready;
  assign out_src = grant;

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    grant_nxt = grant;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (enable && (|cand)) begin
          grant_nxt = LINK_W'(rr_next(16'(cand), 32'(ptr), N_LINKS));
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        out_valid        = req_valid[grant];
        out_last         = req_last[grant];
        out_data         = lane[grant];
        req_ready[grant] = out_ready;
        if ((xfer && req_last[grant]) || abort) begin
          ptr_nxt   = grant;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ptr   <= LINK_W'(N_LINKS - 1);
      grant <= '0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      grant <= grant_nxt;
    end
  end

`ifdef DTC_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wd_cnt;
  logic             err_q;

  // Abort on the stalled cycle that would bring the count to TIMEOUT.
  assign abort = busy && !xfer && (wd_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (!busy || xfer || abort) wd_cnt <= '0;
      else                        wd_cnt <= wd_cnt + 1'b1;
      if (abort) err_q <= 1'b1;
    end
  end

  assign timeout_err = err_q;
`else
  assign abort       = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_dtc_input_arbiter.sv
// Randomized self-checking bench for dtc_input_arbiter against a frame-level reference model.
module tb_dtc_input_arbiter;

  localparam int N  = 4;
  localparam int W  = 64;
  localparam int LW = 2;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_last;
  logic [N*W-1:0] req_data;
  logic [N-1:0]  req_ready;
  logic          out_valid;
  logic [W-1:0]  out_data;
  logic          out_last;
  logic [LW-1:0] out_src;
  logic          out_ready;
  logic [N-1:0]  armed;
  logic          timeout_err;

  always #5 clk = ~clk;

  dtc_input_arbiter #(
    .N_LINKS (N),
    .DATA_W  (W),
    .LINK_W  (LW),
    .TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .req_valid   (req_valid),
    .req_last    (req_last),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_last    (out_last),
    .out_src     (out_src),
    .out_ready   (out_ready),
    .armed       (armed),
    .timeout_err (timeout_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: which link owns the bus, who was served last, who is armed.
  bit [N-1:0] m_armed;
  bit         m_busy;
  bit         m_err;
  int         m_grant;
  int         m_ptr;
  int         m_stall;

  // Per-link traffic sources.
  int          seq  [N];
  int          beat [N];
  int          len  [N];
  int          fixed_len;
  bit [N-1:0]  vmask;
  int unsigned prob;
  bit          rnd_ready;
  int          grant_log [$];
  int          exp_order [4] = '{0, 1, 3, 0};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input bit [N-1:0] c, input int p);
    for (int k = 1; k <= N; k++) begin
      if (c[(p + k) % N]) return (p + k) % N;
    end
    return p;
  endfunction

  task automatic model_reset();
    m_armed = '0;
    m_busy  = 1'b0;
    m_err   = 1'b0;
    m_grant = 0;
    m_ptr   = N - 1;
    m_stall = 0;
  endtask

  task automatic gen_clear();
    for (int i = 0; i < N; i++) begin
      beat[i] = 0;
      len[i]  = (fixed_len != 0) ? fixed_len : int'($urandom_range(4, 1));
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = vmask[i] && ($urandom_range(99) < prob);
      req_last[i]        = (beat[i] == len[i] - 1);
      req_data[i*W +: W] = {32'(i), 32'(seq[i])};
    end
    if (rnd_ready) out_ready = 1'($urandom_range(1));
  endtask

  task automatic step();
    bit [N-1:0]  exp_ready;
    bit [N-1:0]  hs;
    bit          exp_v;
    bit          exp_l;
    logic [63:0] exp_d;
    bit          xfer;
    exp_ready = '0;
    exp_v     = 1'b0;
    exp_l     = 1'b0;
    exp_d     = '0;
    @(negedge clk);
    if (m_busy) begin
      exp_v              = req_valid[m_grant];
      exp_l              = req_last[m_grant];
      exp_d              = req_data[m_grant*W +: W];
      exp_ready[m_grant] = out_ready;
    end
    check("out_valid",   64'(out_valid),   64'(exp_v));
    check("out_last",    64'(out_last),    64'(exp_l));
    check("out_src",     64'(out_src),     64'(m_grant));
    check("out_data",    out_data,         exp_d);
    check("req_ready",   64'(req_ready),   64'(exp_ready));
    check("armed",       64'(armed),       64'(m_armed));
    check("timeout_err", 64'(timeout_err), 64'(m_err));
    xfer = exp_v && out_ready;
    hs   = req_valid & exp_ready;
    if (xfer && !reset && beat[m_grant] == 0) grant_log.push_back(m_grant);
    if (reset) begin
      model_reset();
    end else begin
      if (!m_busy) begin
        if (enable && (|(m_armed & req_valid))) begin
          m_grant = pick(m_armed & req_valid, m_ptr);
          m_busy  = 1'b1;
          m_stall = 0;
        end
      end else if (xfer) begin
        m_stall = 0;
        if (exp_l) begin
          m_ptr  = m_grant;
          m_busy = 1'b0;
        end
      end else begin
`ifdef DTC_ARB_TIMEOUT_EN
        m_stall++;
        if (m_stall == TO) begin
          m_ptr  = m_grant;
          m_busy = 1'b0;
          m_err  = 1'b1;
        end
`endif
      end
      if (enable) m_armed = m_armed | req_valid;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (hs[i]) begin
        seq[i]++;
        if (beat[i] == len[i] - 1) begin
          beat[i] = 0;
          len[i]  = (fixed_len != 0) ? fixed_len : int'($urandom_range(4, 1));
        end else begin
          beat[i]++;
        end
      end
    end
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      drive();
      step();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive();
    step();
    reset = 1'b0;
    gen_clear();
  endtask

  initial begin
    reset     = 1'b1;
    enable    = 1'b0;
    out_ready = 1'b1;
    req_valid = '0;
    req_last  = '0;
    req_data  = '0;
    rnd_ready = 1'b0;
    prob      = 100;
    vmask     = '0;
    fixed_len = 3;
    for (int i = 0; i < N; i++) seq[i] = 0;
    gen_clear();
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    step();
    check("rst_out_data", out_data, 64'h0);
    reset  = 1'b0;
    enable = 1'b1;

    // Link 2 alone: armed after one edge, first word visible one edge later
    vmask = 4'b0100;
    run(1);
    check("arm_link2", 64'(armed), 64'(4'b0100));
    run(1);
    check("link2_valid", 64'(out_valid), 64'h1);
    check("link2_src",   64'(out_src),   64'h2);
    run(6);
    vmask = '0;
    run(3);

    // Links 0,1,3 streaming 3-word frames: round-robin order
    do_reset();
    vmask = 4'b1011;
    grant_log.delete();
    run(18);
    check("order_count", 64'(grant_log.size() >= 4), 64'h1);
    for (int k = 0; k < 4; k++) begin
      if (k < grant_log.size()) check("order", 64'(grant_log[k]), 64'(exp_order[k]));
    end
    vmask = '0;
    run(3);

    // Back-pressure during a frame of link 1
    do_reset();
    vmask = 4'b0010;
    run(2);
    for (int k = 0; k < 8; k++) begin
      out_ready = (k % 2 == 0);
      drive();
      step();
    end
    out_ready = 1'b1;
    vmask = '0;
    run(3);

    // enable falls mid-frame: frame completes, no new grants
    fixed_len = 4;
    do_reset();
    vmask = 4'b0011;
    grant_log.delete();
    run(4);
    enable = 1'b0;
    run(10);
    check("en_grants", 64'(grant_log.size()), 64'h1);
    check("en_idle",   64'(out_valid),        64'h0);
    enable = 1'b1;

    // Reset during word 2 of a frame, then link 0 wins first
    do_reset();
    vmask = 4'b0001;
    run(3);
    reset = 1'b1;
    drive();
    step();
    reset = 1'b0;
    check("mid_rst_valid", 64'(out_valid), 64'h0);
    check("mid_rst_armed", 64'(armed),     64'h0);
    check("mid_rst_src",   64'(out_src),   64'h0);
    gen_clear();
    vmask = 4'b1111;
    grant_log.delete();
    run(4);
    check("mid_rst_first", 64'((grant_log.size() > 0) ? grant_log[0] : -1), 64'h0);

    // Randomized traffic, back-pressure, enable and occasional reset
    fixed_len = 0;
    rnd_ready = 1'b1;
    gen_clear();
    for (int c = 0; c < 1500; c++) begin
      if (c % 40 == 0) begin
        vmask  = 4'($urandom);
        prob   = $urandom_range(100, 40);
        enable = ($urandom_range(9) != 0);
      end
      reset = ($urandom_range(199) == 0);
      drive();
      step();
      reset = 1'b0;
    end

`ifdef DTC_ARB_TIMEOUT_EN
    // Granted link goes silent without a last word
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    enable    = 1'b1;
    prob      = 100;
    fixed_len = 16;
    do_reset();
    vmask = 4'b0011;
    run(3);
    vmask = 4'b0010;
    run(TO);
    check("to_err", 64'(timeout_err), 64'h1);
    run(1);
    check("to_next_src",   64'(out_src),   64'h1);
    check("to_next_valid", 64'(out_valid), 64'h1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dtc_input_arbiter.md
# dtc_input_arbiter

Round-robin arbiter that shares one downstream frame bus between N_LINKS DTC input links in the InputDTC stage. Each link is armed by a sticky per-link flag on its first valid word. Once armed, the link competes for the bus and, when granted, holds it for a whole frame, from its first word to its last. The watchdog that force-releases a stalled frame is optional.

## Interface
- N_LINKS, 4, number of input links (2..16)
- DATA_W, 64, word width
- LINK_W, $clog2(N_LINKS), width of source index
- TIMEOUT, 1024, watchdog limit in cycles (used only with the watchdog compiled in)

- clk  in  1  clock; all logic is on the rising edge
- reset  in  1  synchronous, active-high reset
- enable  in  1  low blocks new grants; a frame in progress completes
- req_valid  in  N_LINKS  per-link word valid
- req_last  in  N_LINKS  per-link last word of frame
- req_data  in  N_LINKS*DATA_W  per-link data; link i occupies [i*DATA_W +: DATA_W]
- req_ready  out  N_LINKS  per-link accept
- out_valid  out  1  downstream valid
- out_data  out  DATA_W  downstream data
- out_last  out  1  downstream last
- out_src  out  LINK_W  index of the granted link
- out_ready  in  1  downstream accept
- armed  out  N_LINKS  sticky per-link armed flags
- timeout_err  out  1  sticky watchdog error

## Operation
- Arming:
  - armed[i] sets on any cycle where req_valid[i]=1 and enable=1.
  - Once set, armed[i] stays set until reset.
  - An unarmed link is never granted; its req_ready stays 0.
- FSM states: IDLE and BUSY.
- IDLE:
  - Candidates are links with armed & req_valid, using registered armed values.
  - If enable=1 and at least one candidate exists, pick the first candidate scanning upward from ptr+1 modulo N_LINKS.
  - Register the pick as grant and go to BUSY.
  - Otherwise stay in IDLE.
- BUSY, combinational pass-through from the granted link g:
  - out_valid = req_valid[g]
  - out_data = req_data[g]
  - out_last = req_last[g]
  - out_src = g
  - req_ready[g] = out_ready
  - all other req_ready bits = 0
- A beat transfers when out_valid & out_ready.
- On a transfer with out_last=1: ptr <= g, go to IDLE.
- enable falling in BUSY has no effect until the frame ends.
- In IDLE: out_valid=0, out_last=0, out_src holds its last value, and all req_ready bits are 0.
- Frames of a single word are legal; they behave as first-and-last.

## Timing
- Reset values:
  - state=IDLE, ptr=N_LINKS-1 (so link 0 wins first), grant=0
  - armed=0, timeout_err=0
  - out_valid=0, out_last=0, out_src=0, out_data=0, req_ready=0
- Arming latency: a link's first valid word sets armed at edge k. The earliest grant is registered at edge k+1; the first word can transfer in the cycle after that.
- Arbitration costs one bubble cycle (IDLE) between consecutive frames.
- Inside a frame, throughput is one word per cycle with zero-latency pass-through.
- Simultaneous events: a last-word transfer and new requests in the same cycle both take effect. New requests are arbitrated in the following IDLE cycle against the updated ptr.
- ptr wraps from N_LINKS-1 to 0.
- Reset asserted mid-frame: everything returns to reset values on the next edge. The frame is abandoned, with no out_last emitted.

## Configuration
- DTC_ARB_TIMEOUT_EN defined:
  - A counter clears on every transfer and on entry to BUSY, and increments on every BUSY cycle without a transfer.
  - When the counter reaches TIMEOUT, go to IDLE, set ptr <= g, and set timeout_err (sticky until reset).
  - The arbiter emits no out_last for the aborted frame.
- DTC_ARB_TIMEOUT_EN undefined:
  - No counter is built; timeout_err is tied to 0.
  - A stalled granted link holds the bus indefinitely.

## Structure
- Package dtc_arb_pkg holds:
  - the state enum (IDLE, BUSY)
  - the default N_LINKS and DATA_W constants
  - a round-robin next-index function
- Sub-module sticky_flag (set input, synchronous active-high reset, output) is instantiated once per armed bit.

## Test plan
- After reset, link 2 sends valid with no other traffic -> armed=4'b0100; out_valid rises two cycles later; out_src=2.
- Links 0, 1 and 3 are all armed and requesting 3-word frames continuously -> grant order 0,1,3,0. Each frame delivers exactly 3 contiguous words with one idle cycle between frames.
- out_ready is toggled 1,0,1,0 during a frame of link 1 -> no words are lost or duplicated; req_ready[1] mirrors out_ready; the other req_ready bits stay 0.
- enable drops in the middle of link 0's frame -> the frame completes; no further grants occur while enable=0, even with requests pending.
- reset is asserted during word 2 of a frame -> on the next cycle, all outputs and armed are 0; link 0 is served first after release.
- With DTC_ARB_TIMEOUT_EN and TIMEOUT=8, the granted link drops valid without a last word -> after 8 stalled cycles, timeout_err=1, the FSM is in IDLE, and the next armed link is granted.
